matrix_result_drain: RTL
========================

# matrix_result_drain

Downstream stage of the unary matrix multiplier. On each rising edge of the multiplier's `finished`, it snapshots the full DIM×DIM result matrix. It then streams the matrix out one row (or column) per beat over a valid/ready interface. This frees the multiplier to be re-armed while the result is consumed.

## Interface
- DIM, default 16: matrix dimension; rows and columns per matrix.
- WIDTH, default 4: operand element width; each result element is 2*WIDTH bits, two's complement.
- TRANSPOSE, default 0: 0 sends row r per beat (elements [r][0..DIM-1]); 1 sends column c per beat (elements [0..DIM-1][c]).
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_mat  in  DIM×DIM×2*WIDTH  multiplier result matrix, packed [row][col][bit].
- finished  in  1  multiplier completion level; stays high until the multiplier is reset.
- m_valid  out  1  beat available.
- m_ready  in  1  consumer accepts beat when high with m_valid.
- m_data  out  DIM×2*WIDTH  one vector, packed [k][bit]; k is column index (TRANSPOSE=0) or row index (TRANSPOSE=1).
- m_index  out  $clog2(DIM)  row/column number of the current beat.
- m_last  out  1  high on the beat with m_index == DIM-1.
- busy  out  1  high while a captured matrix is not fully drained.
- overrun  out  1  sticky; set when a capture is refused because the buffer is busy.

## Operation
- States: IDLE and SEND.
- Edge detect: `fin_q` registers `finished`. A rise is `finished & ~fin_q`. `fin_q` resets to 0, so `finished` already high when reset releases counts as a rise.
- IDLE + rise:
  - latch in_mat into the snapshot buffer;
  - idx := 0;
  - go to SEND.
- SEND:
  - m_valid = 1;
  - m_data = snapshot vector idx per TRANSPOSE;
  - m_index = idx;
  - m_last = (idx == DIM-1).
- Handshake in SEND (m_valid & m_ready) with idx < DIM-1: idx increments. With m_ready low, m_data, m_index and m_last hold exactly; idx does not wrap.
- Handshake on the last beat:
  - return to IDLE;
  - if a rise occurs in that same cycle, capture the new matrix, reset idx to 0 and remain in SEND (back-to-back drain, no bubble).
- Rise in SEND other than on the final handshake: matrix not captured; overrun := 1. Snapshot and idx are unaffected.
- overrun clears only on reset.
- busy = (state == SEND).
- Data is passed bit-exact; no sign extension or arithmetic. Snapshot is in_mat as sampled on the capture edge.
- Reset (any time, including mid-drain):
  - state := IDLE; idx := 0; fin_q := 0; overrun := 0;
  - m_valid, m_last, busy, m_index := 0;
  - snapshot buffer not reset (m_data don't-care while m_valid is 0; drive 0 from buffer content is acceptable).

## Timing
- Capture latency: rise sampled at edge N → m_valid high after edge N, row 0 presented in cycle N+1.
- Throughput: one beat per cycle with m_ready held high. A full matrix takes DIM cycles; m_valid drops the cycle after the last handshake unless a same-cycle recapture occurs.
- All outputs are registered state or decode of state/idx; no combinational path from m_ready to m_valid.
- m_data is a mux of registered snapshot by registered idx.
- finished low→high→low→high across multiplier resets produces one capture per rise.
- A level held high never recaptures.

## Structure
- Shared package (mm_pkg): result element width function RES_W(WIDTH) = 2*WIDTH, and the drain state enum {IDLE, SEND}. The multiplier and any later stages reuse both.
- Natural sub-module: `matrix_vector_select`. It is combinational: given snapshot, idx and TRANSPOSE, it produces the DIM-element vector. The FSM, edge detect, buffer and flags stay in the top.

## Test plan
- DIM=4, WIDTH=4, in_mat[r][c]=r*4+c, finished rise, m_ready=1 → 4 beats on consecutive cycles, m_index 0..3, m_data row r = {r*4+3,…,r*4}, m_last only on beat 3, busy low after.
- Same matrix, TRANSPOSE=1 → beat c carries {12+c, 8+c, 4+c, c}.
- m_ready toggled 1,0,0,1,… → m_data/m_index stable while stalled; exactly 4 accepted beats; no duplicates or skips.
- Second finished rise at beat 1, then in_mat changed → overrun=1, original matrix drained unchanged. Rise exactly on last handshake → new matrix starts next cycle, m_valid never drops, overrun stays 0.
- Negative results (element 8'hF4 = -12) → emitted bit-exact as 8'hF4.
- reset asserted mid-drain at beat 2 → next cycle m_valid=0, busy=0, overrun=0. finished still high after reset → recapture, stream restarts at m_index 0.

Source files
------------

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared matrix multiplier types and element width helper
package mm_pkg;

  // Width of one result element; the product of two WIDTH-bit operands.
  function automatic int RES_W(input int width);
    return 2 * width;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

endpackage

// File: rtl/matrix_result_drain_if.sv
// rtl/matrix_result_drain_if.sv - result vector stream, one row or column per beat
interface matrix_result_drain_if #(
  parameter int DIM = 16,
  parameter int EW  = 8
);
  localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                   m_valid;
  logic                   m_ready;
  logic [DIM-1:0][EW-1:0] m_data;
  logic [IW-1:0]          m_index;
  logic                   m_last;

  modport master (output m_valid, m_data, m_index, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_index, m_last, output m_ready);
endinterface

// File: rtl/matrix_result_drain_vector_select.sv
// rtl/matrix_result_drain_vector_select.sv - pick one row or column out of the snapshot
module matrix_vector_select #(
  parameter int DIM       = 16,
  parameter int EW        = 8,
  parameter int IW        = 4,
  parameter int TRANSPOSE = 0
) (
  input  logic [DIM-1:0][DIM-1:0][EW-1:0] snap_i,
  input  logic [IW-1:0]                   idx_i,
  output logic [DIM-1:0][EW-1:0]          vec_o
);

  // Element k of the beat is column k of row idx, or row k of column idx.
  always_comb begin
    vec_o = '0;
    for (int k = 0; k < DIM; k++) begin
      if (TRANSPOSE != 0) vec_o[k] = snap_i[k][idx_i];
      else                vec_o[k] = snap_i[idx_i][k];
    end
  end

endmodule

// File: rtl/matrix_result_drain.sv
// rtl/matrix_result_drain.sv - snapshot a finished result matrix and stream it one vector per beat
module matrix_result_drain
  import mm_pkg::*;
#(
  parameter int DIM       = 16,
  parameter int WIDTH     = 4,
  parameter int TRANSPOSE = 0
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [DIM-1:0][DIM-1:0][RES_W(WIDTH)-1:0] in_mat,
  input  logic                                     finished,
  matrix_result_drain_if.master                    m,
  output logic                                     busy,
  output logic                                     overrun
);

  localparam int            EW       = RES_W(WIDTH);
  localparam int            IW       = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIM - 1);

  drain_state_e                   state_q;
  logic [IW-1:0]                  idx_q;
  logic                           fin_q;
  logic                           overrun_q;
  logic [DIM-1:0][DIM-1:0][EW-1:0] snap_q;
  logic [DIM-1:0][EW-1:0]          vec;

  logic rise;
  logic handshake;
  logic last_beat;
  logic capture;

  // A capture is accepted when idle, or when the final beat leaves in the same cycle.
  assign rise      = finished & ~fin_q;
  assign handshake = (state_q == SEND) & m.m_ready;
  assign last_beat = (idx_q == LAST_IDX);
  assign capture   = rise & ((state_q == IDLE) | (handshake & last_beat));

  // Snapshot buffer; content is irrelevant until a capture, so it has no reset.
  always_ff @(posedge clk) begin
    if (capture) snap_q <= in_mat;
  end

  // Drain FSM with rise detect and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      fin_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      fin_q <= finished;
      if (rise & ~capture) overrun_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (capture) begin
            state_q <= SEND;
            idx_q   <= '0;
          end
        end
        SEND: begin
          if (handshake) begin
            if (!last_beat) begin
              idx_q <= idx_q + IW'(1);
            end else begin
              idx_q <= '0;
              if (!capture) state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  matrix_vector_select #(
    .DIM       (DIM),
    .EW        (EW),
    .IW        (IW),
    .TRANSPOSE (TRANSPOSE)
  ) u_select (
    .snap_i (snap_q),
    .idx_i  (idx_q),
    .vec_o  (vec)
  );

  assign m.m_valid = (state_q == SEND);
  assign m.m_data  = vec;
  assign m.m_index = idx_q;
  assign m.m_last  = (state_q == SEND) & last_beat;
  assign busy      = (state_q == SEND);
  assign overrun   = overrun_q;

endmodule
